// File: rtl/ft240x_sram_loader.sv
`timescale 1ns/1ps
// ft240x_sram_loader
// Load-mode front end of the EPROM emulator. Pulls command bytes out of the
// FT240X receive FIFO and writes 16-bit words into the emulation SRAM. It
// also answers a ping byte with 'K' so the host can check the link.
//
// Commands (first byte):
//   'A' 0x41 + 3 address bytes, LSB first; bits [23:18] are dropped
//   'W' 0x57 + 2 data bytes, low then high; writes at addr, then addr += 1
//   'P' 0x50 -> reply 0x4B
//   anything else is ignored
//
// Ports:
//   clk24MHz, nReset          clock from the FT240X, async active-low reset
//   load_en                   1 = loader owns the SRAM and FIFO buses
//   ft240x_d_in/_out/_oe      split FIFO data bus
//   ft240x_nRD, ft240x_nWR    FIFO strobes, active low
//   ft240x_RXF, ft240x_TXE    FIFO flags (high = empty / full), unsynchronised
//   sram_addr, sram_data_out  SRAM word address (load pointer) and write data
//   sram_data_oe              1 = drive the SRAM data bus
//   sram_nCS..sram_nLB        SRAM controls, active low; nOE is tied high
//   busy                      1 = FSM not idle
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | waiting for a byte in the receive FIFO while load_en = 1
// ST_RD_LOW   | nRD low; byte latched on the last low cycle
// ST_RD_HIGH  | nRD high recovery before RXF is looked at again
// ST_DISPATCH | decode the byte as a command or as payload
// ST_SRAM_WR  | SRAM write: setup cycle, WE_LOW cycles of nWE low, hold cycle
// ST_TX_WAIT  | ping reply pending, waiting for room in the transmit FIFO
// ST_TX_LOW   | drive 'K': d_oe lead cycle, WR_LOW cycles of nWR low, d_oe tail

module ft240x_sram_loader #(
    parameter int RD_LOW  = 2,
    parameter int RD_HIGH = 2,
    parameter int WR_LOW  = 2,
    parameter int WE_LOW  = 2
) (
    input  logic        clk24MHz,
    input  logic        nReset,
    input  logic        load_en,
    input  logic [7:0]  ft240x_d_in,
    output logic [7:0]  ft240x_d_out,
    output logic        ft240x_d_oe,
    output logic        ft240x_nRD,
    output logic        ft240x_nWR,
    input  logic        ft240x_RXF,
    input  logic        ft240x_TXE,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_data_out,
    output logic        sram_data_oe,
    output logic        sram_nCS,
    output logic        sram_nWE,
    output logic        sram_nOE,
    output logic        sram_nUB,
    output logic        sram_nLB,
    output logic        busy
);

    localparam int CW = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LOW,
        ST_RD_HIGH,
        ST_DISPATCH,
        ST_SRAM_WR,
        ST_TX_WAIT,
        ST_TX_LOW
    } state_t;

    typedef enum logic [1:0] {
        PL_CMD,
        PL_ADDR,
        PL_DATA
    } payload_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    payload_t        mode;
    logic [1:0]      idx;
    logic [7:0]      rx_byte;
    logic [15:0]     addr_buf;
    logic [7:0]      data_lo;
    logic [17:0]     addr;

    logic rxf_meta, rxf_s, txe_meta, txe_s;

    // Flags reset to "empty/full" so nothing starts before they are sampled.
    always_ff @(posedge clk24MHz or negedge nReset) begin
        if (!nReset) begin
            rxf_meta <= 1'b1;
            rxf_s    <= 1'b1;
            txe_meta <= 1'b1;
            txe_s    <= 1'b1;
        end else begin
            rxf_meta <= ft240x_RXF;
            rxf_s    <= rxf_meta;
            txe_meta <= ft240x_TXE;
            txe_s    <= txe_meta;
        end
    end

    always_ff @(posedge clk24MHz or negedge nReset) begin
        if (!nReset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Timed states count down to zero and leave on the terminal count.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (load_en && !rxf_s) begin
                    state_nx = ST_RD_LOW;
                    cnt_nx   = CW'(RD_LOW - 1);
                end
            end
            ST_RD_LOW: begin
                if (cnt == '0) begin
                    state_nx = ST_RD_HIGH;
                    cnt_nx   = CW'(RD_HIGH - 1);
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_RD_HIGH: begin
                if (cnt == '0) state_nx = ST_DISPATCH;
                else           cnt_nx   = cnt - 1'b1;
            end
            ST_DISPATCH: begin
                state_nx = ST_IDLE;
                if (load_en) begin
                    if (mode == PL_CMD && rx_byte == 8'h50) begin
                        state_nx = ST_TX_WAIT;
                    end else if (mode == PL_DATA && idx == 2'd1) begin
                        state_nx = ST_SRAM_WR;
                        cnt_nx   = CW'(WE_LOW + 1);
                    end
                end
            end
            ST_SRAM_WR: begin
                if (cnt == '0) state_nx = ST_IDLE;
                else           cnt_nx   = cnt - 1'b1;
            end
            ST_TX_WAIT: begin
                if (!load_en) begin
                    state_nx = ST_IDLE;
                end else if (!txe_s) begin
                    state_nx = ST_TX_LOW;
                    cnt_nx   = CW'(WR_LOW + 1);
                end
            end
            ST_TX_LOW: begin
                if (cnt == '0) state_nx = ST_IDLE;
                else           cnt_nx   = cnt - 1'b1;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Command/payload tracking. Dropping load_en discards a partial command
    // but never touches the address pointer.
    always_ff @(posedge clk24MHz or negedge nReset) begin
        if (!nReset) begin
            mode          <= PL_CMD;
            idx           <= 2'd0;
            rx_byte       <= 8'h00;
            addr_buf      <= 16'h0000;
            data_lo       <= 8'h00;
            addr          <= 18'h00000;
            sram_data_out <= 16'h0000;
            ft240x_d_out  <= 8'h00;
        end else begin
            if (state == ST_RD_LOW && cnt == '0)
                rx_byte <= ft240x_d_in;

            if (!load_en && (state == ST_IDLE || state == ST_DISPATCH)) begin
                mode <= PL_CMD;
                idx  <= 2'd0;
            end else if (state == ST_DISPATCH) begin
                case (mode)
                    PL_CMD: begin
                        idx <= 2'd0;
                        case (rx_byte)
                            8'h41:   mode <= PL_ADDR;
                            8'h57:   mode <= PL_DATA;
                            8'h50:   ft240x_d_out <= 8'h4B;
                            default: mode <= PL_CMD;
                        endcase
                    end
                    PL_ADDR: begin
                        idx <= idx + 2'd1;
                        case (idx)
                            2'd0:    addr_buf[7:0]  <= rx_byte;
                            2'd1:    addr_buf[15:8] <= rx_byte;
                            default: begin
                                addr <= {rx_byte[1:0], addr_buf};
                                mode <= PL_CMD;
                            end
                        endcase
                    end
                    PL_DATA: begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd0) begin
                            data_lo <= rx_byte;
                        end else begin
                            sram_data_out <= {rx_byte, data_lo};
                            mode          <= PL_CMD;
                        end
                    end
                    default: mode <= PL_CMD;
                endcase
            end

            if (state == ST_SRAM_WR && cnt == '0)
                addr <= addr + 18'd1;
        end
    end

    assign sram_addr = addr;
    assign sram_nOE  = 1'b1;

    // Strobes are registered from the next-state decode: they line up with
    // the state they belong to, are glitch-free, and clear asynchronously.
    logic nrd_nx, nwr_nx, doe_nx, wr_nx, nwe_nx, busy_nx;

    always_comb begin
        nrd_nx  = (state_nx != ST_RD_LOW);
        doe_nx  = (state_nx == ST_TX_LOW);
        nwr_nx  = !(state_nx == ST_TX_LOW && cnt_nx != '0 && cnt_nx <= CW'(WR_LOW));
        wr_nx   = (state_nx == ST_SRAM_WR);
        nwe_nx  = !(state_nx == ST_SRAM_WR && cnt_nx != '0 && cnt_nx <= CW'(WE_LOW));
        busy_nx = (state_nx != ST_IDLE);
    end

    always_ff @(posedge clk24MHz or negedge nReset) begin
        if (!nReset) begin
            ft240x_nRD   <= 1'b1;
            ft240x_nWR   <= 1'b1;
            ft240x_d_oe  <= 1'b0;
            sram_data_oe <= 1'b0;
            sram_nCS     <= 1'b1;
            sram_nWE     <= 1'b1;
            sram_nUB     <= 1'b1;
            sram_nLB     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            ft240x_nRD   <= nrd_nx;
            ft240x_nWR   <= nwr_nx;
            ft240x_d_oe  <= doe_nx;
            sram_data_oe <= wr_nx;
            sram_nCS     <= !wr_nx;
            sram_nWE     <= nwe_nx;
            sram_nUB     <= !wr_nx;
            sram_nLB     <= !wr_nx;
            busy         <= busy_nx;
        end
    end

endmodule
